tl_master_bridge: RTL and testbench

- Synthesizable TileLink-UL initiator for the CEP co-simulation environment; the requesting end of the TL-UL A/D link.
- Converts a simple system-side req/ack read/write interface into single-beat A-channel Get/PutFullData/PutPartialData requests.
- Collects the D-channel response and returns read data and an error flag to the system side.
- At most one transaction outstanding; per-transaction source ID; response timeout so the bridge cannot hang.

---
 rtl/tl_master_bridge.sv | 172 +++++++++++++++++
 tb/tb_tl_master_bridge.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tl_master_bridge.sv
// ============================================================================
// Module   : tl_master_bridge
// Purpose  : TileLink-UL initiator turning a req/ack read/write port into
//            single-beat Get/PutFullData/PutPartialData transactions.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tl_master_bridge #(
    parameter int SRC_SIZE       = 2,
    parameter int SINK_SIZE      = 3,
    parameter int BUS_SIZE       = 8,
    parameter int ADR_WIDTH      = 32,
    parameter int TIMEOUT_CYCLES = 1024,
    localparam int TL_SIZE       = $clog2(BUS_SIZE),
    localparam int DATA_WIDTH    = BUS_SIZE * 8
) (
    input  logic                  clock,
    input  logic                  reset,

    input  logic                  req,
    input  logic [ADR_WIDTH-1:0]  adr,
    input  logic                  rdWr,
    input  logic [DATA_WIDTH-1:0] wrDat,
    input  logic [BUS_SIZE-1:0]   wrMask,
    output logic                  ack,
    output logic [DATA_WIDTH-1:0] rdDat,
    output logic                  err,

    input  logic                  tl_a_ready,
    output logic                  tl_a_valid,
    output logic [2:0]            tl_a_bits_opcode,
    output logic [2:0]            tl_a_bits_param,
    output logic [TL_SIZE-1:0]    tl_a_bits_size,
    output logic [SRC_SIZE-1:0]   tl_a_bits_source,
    output logic [ADR_WIDTH-1:0]  tl_a_bits_address,
    output logic [BUS_SIZE-1:0]   tl_a_bits_mask,
    output logic [DATA_WIDTH-1:0] tl_a_bits_data,
    output logic                  tl_a_bits_corrupt,

    output logic                  tl_d_ready,
    input  logic                  tl_d_valid,
    input  logic [2:0]            tl_d_bits_opcode,
    input  logic [1:0]            tl_d_bits_param,
    input  logic [TL_SIZE-1:0]    tl_d_bits_size,
    input  logic [SRC_SIZE-1:0]   tl_d_bits_source,
    input  logic [SINK_SIZE-1:0]  tl_d_bits_sink,
    input  logic                  tl_d_bits_denied,
    input  logic [DATA_WIDTH-1:0] tl_d_bits_data,
    input  logic                  tl_d_bits_corrupt
);

    localparam logic [2:0] OP_GET          = 3'd4;
    localparam logic [2:0] OP_PUT_FULL     = 3'd0;
    localparam logic [2:0] OP_PUT_PARTIAL  = 3'd1;
    localparam logic [2:0] OP_ACCESS_ACK   = 3'd0;
    localparam logic [2:0] OP_ACCESS_DATA  = 3'd1;

    localparam int               CNT_W        = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        A_SEND  = 3'd1,
        D_WAIT  = 3'd2,
        DONE    = 3'd3,
        REQ_LOW = 3'd4
    } state_t;

    state_t                state;
    logic [SRC_SIZE-1:0]   src_id;
    logic [CNT_W-1:0]      wait_cnt;
    logic                  is_read;
    logic                  d_hit;
    logic [2:0]            expected_d_opcode;
    logic                  unused_inputs;

    assign unused_inputs = ^{tl_d_bits_param, tl_d_bits_size, tl_d_bits_sink};

    assign tl_a_bits_param   = 3'd0;
    assign tl_a_bits_corrupt = 1'b0;

    // Stale beats are drained in IDLE so a late responder never backs up the link.
    assign tl_d_ready = reset && ((state == IDLE) || (state == D_WAIT));

    assign d_hit             = tl_d_valid && tl_d_ready && (tl_d_bits_source == src_id);
    assign expected_d_opcode = is_read ? OP_ACCESS_DATA : OP_ACCESS_ACK;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state             <= IDLE;
            src_id            <= '0;
            wait_cnt          <= '0;
            is_read           <= 1'b0;
            ack               <= 1'b0;
            err               <= 1'b0;
            rdDat             <= '0;
            tl_a_valid        <= 1'b0;
            tl_a_bits_opcode  <= '0;
            tl_a_bits_size    <= '0;
            tl_a_bits_source  <= '0;
            tl_a_bits_address <= '0;
            tl_a_bits_mask    <= '0;
            tl_a_bits_data    <= '0;
        end else begin
            ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        is_read           <= rdWr;
                        tl_a_valid        <= 1'b1;
                        tl_a_bits_size    <= TL_SIZE'(TL_SIZE);
                        tl_a_bits_source  <= src_id;
                        tl_a_bits_address <= {adr[ADR_WIDTH-1:TL_SIZE], {TL_SIZE{1'b0}}};
                        if (rdWr) begin
                            tl_a_bits_opcode <= OP_GET;
                            tl_a_bits_mask   <= '1;
                            tl_a_bits_data   <= '0;
                        end else begin
                            tl_a_bits_opcode <= (&wrMask) ? OP_PUT_FULL : OP_PUT_PARTIAL;
                            tl_a_bits_mask   <= wrMask;
                            tl_a_bits_data   <= wrDat;
                        end
                        rdDat <= '0;
                        err   <= 1'b0;
                        state <= A_SEND;
                    end
                end
                A_SEND: begin
                    if (tl_a_ready) begin
                        tl_a_valid <= 1'b0;
                        wait_cnt   <= '0;
                        state      <= D_WAIT;
                    end
                end
                D_WAIT: begin
                    // A matching beat wins over a timeout landing on the same edge.
                    if (d_hit) begin
                        rdDat <= is_read ? tl_d_bits_data : '0;
                        err   <= tl_d_bits_denied || tl_d_bits_corrupt ||
                                 (tl_d_bits_opcode != expected_d_opcode);
                        ack   <= 1'b1;
                        state <= DONE;
                    end else if (wait_cnt == TIMEOUT_LAST) begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                        rdDat    <= '0;
                        err      <= 1'b1;
                        ack      <= 1'b1;
                        state    <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    src_id <= src_id + SRC_SIZE'(1);
                    state  <= REQ_LOW;
                end
                REQ_LOW: begin
                    if (!req) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_tl_master_bridge.sv
// ============================================================================
// Module   : tb_tl_master_bridge
// Purpose  : Randomized scoreboard bench for tl_master_bridge.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tl_master_bridge;

    localparam int TMO = 16;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        req = 1'b0;
    logic [31:0] adr = '0;
    logic        rdWr = 1'b0;
    logic [63:0] wrDat = '0;
    logic [7:0]  wrMask = '0;
    logic        ack;
    logic [63:0] rdDat;
    logic        err;
    logic        tl_a_ready = 1'b0;
    logic        tl_a_valid;
    logic [2:0]  tl_a_bits_opcode;
    logic [2:0]  tl_a_bits_param;
    logic [2:0]  tl_a_bits_size;
    logic [1:0]  tl_a_bits_source;
    logic [31:0] tl_a_bits_address;
    logic [7:0]  tl_a_bits_mask;
    logic [63:0] tl_a_bits_data;
    logic        tl_a_bits_corrupt;
    logic        tl_d_ready;
    logic        tl_d_valid = 1'b0;
    logic [2:0]  tl_d_bits_opcode = '0;
    logic [1:0]  tl_d_bits_param = '0;
    logic [2:0]  tl_d_bits_size = '0;
    logic [1:0]  tl_d_bits_source = '0;
    logic [2:0]  tl_d_bits_sink = '0;
    logic        tl_d_bits_denied = 1'b0;
    logic [63:0] tl_d_bits_data = '0;
    logic        tl_d_bits_corrupt = 1'b0;

    tl_master_bridge #(
        .SRC_SIZE(2), .SINK_SIZE(3), .BUS_SIZE(8), .ADR_WIDTH(32), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clock(clock), .reset(reset),
        .req(req), .adr(adr), .rdWr(rdWr), .wrDat(wrDat), .wrMask(wrMask),
        .ack(ack), .rdDat(rdDat), .err(err),
        .tl_a_ready(tl_a_ready), .tl_a_valid(tl_a_valid),
        .tl_a_bits_opcode(tl_a_bits_opcode), .tl_a_bits_param(tl_a_bits_param),
        .tl_a_bits_size(tl_a_bits_size), .tl_a_bits_source(tl_a_bits_source),
        .tl_a_bits_address(tl_a_bits_address), .tl_a_bits_mask(tl_a_bits_mask),
        .tl_a_bits_data(tl_a_bits_data), .tl_a_bits_corrupt(tl_a_bits_corrupt),
        .tl_d_ready(tl_d_ready), .tl_d_valid(tl_d_valid),
        .tl_d_bits_opcode(tl_d_bits_opcode), .tl_d_bits_param(tl_d_bits_param),
        .tl_d_bits_size(tl_d_bits_size), .tl_d_bits_source(tl_d_bits_source),
        .tl_d_bits_sink(tl_d_bits_sink), .tl_d_bits_denied(tl_d_bits_denied),
        .tl_d_bits_data(tl_d_bits_data), .tl_d_bits_corrupt(tl_d_bits_corrupt)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [2:0]  opcode;
        logic [1:0]  source;
        logic [31:0] address;
        logic [7:0]  mask;
        logic [63:0] data;
    } a_exp_t;

    typedef struct packed {
        logic [63:0] rd;
        logic        err;
    } ack_exp_t;

    a_exp_t   a_q[$];
    ack_exp_t ack_q[$];
    int       passed = 0;
    int       total = 0;
    logic [1:0] src_model = 2'd0;
    logic     prev_ack = 1'b0;

    task automatic check(input string name, input bit ok, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (ok) passed++;
        else $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    endtask

    task automatic abort_run(input string name);
        total++;
        $display("FAIL %s: bounded wait expired", name);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Scoreboard monitor: A requests and acks are compared as the DUT presents them.
    always @(negedge clock) begin
        a_exp_t   ea;
        ack_exp_t ek;
        if (tl_a_valid) begin
            if (a_q.size() == 0) begin
                check("a_unexpected", 1'b0, 128'(tl_a_bits_opcode), 128'(0));
            end else begin
                ea = a_q[0];
                check("a_fields",
                      ({tl_a_bits_opcode, tl_a_bits_source, tl_a_bits_address,
                        tl_a_bits_mask, tl_a_bits_data} == ea) &&
                      tl_a_bits_param == 3'd0 && tl_a_bits_size == 3'd3 && !tl_a_bits_corrupt,
                      128'({tl_a_bits_opcode, tl_a_bits_source, tl_a_bits_address,
                            tl_a_bits_mask, tl_a_bits_data}), 128'(ea));
                if (tl_a_ready) void'(a_q.pop_front());
            end
        end
        if (ack) begin
            if (ack_q.size() == 0) begin
                check("ack_unexpected", 1'b0, 128'(ack), 128'(0));
            end else begin
                ek = ack_q.pop_front();
                check("ack_resp", {rdDat, err} == ek, 128'({rdDat, err}), 128'(ek));
            end
        end
        if (ack && prev_ack) check("ack_pulse", 1'b0, 128'(1), 128'(0));
        prev_ack = ack;
    end

    task automatic drive_d(input logic [1:0] src, input logic [2:0] opc, input logic [63:0] data,
                           input bit den, input bit cor);
        tl_d_valid        = 1'b1;
        tl_d_bits_source  = src;
        tl_d_bits_opcode  = opc;
        tl_d_bits_data    = data;
        tl_d_bits_denied  = den;
        tl_d_bits_corrupt = cor;
        tl_d_bits_param   = 2'($urandom);
        tl_d_bits_sink    = 3'($urandom);
        tl_d_bits_size    = 3'd3;
    endtask

    function automatic a_exp_t a_model(input bit rd, input logic [31:0] a, input logic [63:0] wd,
                                       input logic [7:0] m, input logic [1:0] s);
        a_exp_t e;
        e.opcode  = rd ? 3'd4 : ((m == 8'hFF) ? 3'd0 : 3'd1);
        e.source  = s;
        e.address = a & ~32'h7;
        e.mask    = rd ? 8'hFF : m;
        e.data    = rd ? 64'h0 : wd;
        return e;
    endfunction

    task automatic issue_a(input bit rd, input logic [31:0] a, input logic [63:0] wd,
                           input logic [7:0] m, input int a_dly);
        int n;
        a_q.push_back(a_model(rd, a, wd, m, src_model));
        req = 1'b1; rdWr = rd; adr = a; wrDat = wd; wrMask = m; tl_a_ready = 1'b0;
        n = 0;
        do begin tick(); n++; end while (!tl_a_valid && n < 10);
        if (!tl_a_valid) abort_run("a_valid_wait");
        check("d_ready_in_a_send", tl_d_ready == 1'b0, 128'(tl_d_ready), 128'(0));
        repeat (a_dly) tick();
        tl_a_ready = 1'b1;
        tick();
        tl_a_ready = 1'b0;
    endtask

    // mode 0: direct response, 1: wrong-source beat first, 2: no response (timeout)
    task automatic txn(input bit rd, input logic [31:0] a, input logic [63:0] wd, input logic [7:0] m,
                       input int a_dly, input int mode, input int d_dly, input logic [63:0] rsp,
                       input bit den, input bit cor, input bit bad_opc, input int hold);
        int n;
        logic [1:0] s;
        logic [2:0] good_opc;
        s = src_model;
        good_opc = rd ? 3'd1 : 3'd0;
        if (mode == 2) ack_q.push_back('{rd: 64'h0, err: 1'b1});
        else ack_q.push_back('{rd: (rd ? rsp : 64'h0), err: (den | cor | bad_opc)});
        issue_a(rd, a, wd, m, a_dly);
        n = 0;
        if (mode == 1) begin
            drive_d(s + 2'd1, good_opc, 64'($urandom), 1'b0, 1'b0);
            tick(); n++;
            tl_d_valid = 1'b0;
        end
        if (mode == 2) begin
            while (!ack && n < 40) begin tick(); n++; end
            check("timeout_latency", ack && n == TMO, 128'(n), 128'(TMO));
        end else begin
            repeat (d_dly) begin tick(); n++; end
            drive_d(s, bad_opc ? ~good_opc : good_opc, rsp, den, cor);
            tick();
            tl_d_valid = 1'b0;
            check("ack_latency", ack == 1'b1, 128'(ack), 128'(1));
        end
        repeat (hold) tick();
        req = 1'b0;
        repeat (2) tick();
        if (mode == 2) begin
            drive_d(s, good_opc, 64'hBAD0_BAD0_BAD0_BAD0, 1'b0, 1'b0);
            check("stale_drained", tl_d_ready == 1'b1, 128'(tl_d_ready), 128'(1));
            tick();
            tl_d_valid = 1'b0;
            tick();
        end
        src_model = s + 2'd1;
    endtask

    initial begin
        logic [1:0] old_src;
        repeat (3) tick();
        check("rst_ack_err", ack == 1'b0 && err == 1'b0, 128'({ack, err}), 128'(0));
        check("rst_rddat", rdDat == 64'h0, 128'(rdDat), 128'(0));
        check("rst_a_valid", tl_a_valid == 1'b0, 128'(tl_a_valid), 128'(0));
        check("rst_a_bits",
              {tl_a_bits_opcode, tl_a_bits_size, tl_a_bits_source, tl_a_bits_address,
               tl_a_bits_mask, tl_a_bits_data} == '0,
              128'({tl_a_bits_opcode, tl_a_bits_size, tl_a_bits_source, tl_a_bits_address,
                    tl_a_bits_mask, tl_a_bits_data}), 128'(0));
        check("rst_d_ready", tl_d_ready == 1'b0, 128'(tl_d_ready), 128'(0));
        reset = 1'b1;
        tick();
        check("idle_d_ready", tl_d_ready == 1'b1, 128'(tl_d_ready), 128'(1));

        // Directed scenarios
        txn(1, 32'h2000_0010, 64'h0, 8'h00, 0, 0, 3, 64'hDEADBEEF_CAFEF00D, 0, 0, 0, 0);
        txn(0, 32'h0000_1007, 64'h1122_3344_5566_7788, 8'hFF, 0, 0, 1, 64'h0, 0, 0, 0, 1);
        txn(0, 32'h0000_1007, 64'h99AA_BBCC_DDEE_FF00, 8'h0F, 0, 0, 2, 64'h0, 0, 0, 0, 0);
        txn(1, 32'h0000_4008, 64'h0, 8'h00, 5, 0, 0, 64'h0123_4567_89AB_CDEF, 0, 0, 0, 3);
        txn(0, 32'h0000_5000, 64'h5555, 8'h33, 0, 1, 2, 64'h0, 1, 0, 0, 0);
        txn(1, 32'h0000_6000, 64'h0, 8'h00, 1, 2, 0, 64'h0, 0, 0, 0, 0);
        txn(1, 32'h0000_7000, 64'h0, 8'h00, 0, 0, TMO - 1, 64'hFEED_FACE_0000_0001, 0, 0, 0, 0);
        txn(0, 32'h0000_8004, 64'hABCD, 8'h00, 0, 0, 0, 64'h0, 0, 0, 0, 0);
        txn(1, 32'h0000_9000, 64'h0, 8'h00, 0, 0, 1, 64'h1234, 0, 0, 1, 0);
        txn(0, 32'h0000_A000, 64'hFFFF, 8'hFF, 0, 0, 1, 64'h0, 0, 1, 0, 0);

        // Back-to-back reads with req toggled, source wraps
        for (int i = 0; i < 5; i++)
            txn(1, 32'h0001_0000 + 32'(i * 8), 64'h0, 8'h00, 0, 0, 0, {32'(i), 32'($urandom)}, 0, 0, 0, 0);

        // Randomized traffic
        for (int i = 0; i < 30; i++) begin
            bit rd;
            int msel, mode;
            logic [7:0] m;
            rd = 1'($urandom);
            msel = $urandom_range(0, 3);
            m = (msel == 0) ? 8'hFF : (msel == 1) ? 8'h00 : 8'($urandom);
            mode = ($urandom_range(0, 7) == 0) ? 2 : (($urandom_range(0, 3) == 0) ? 1 : 0);
            txn(rd, $urandom, {$urandom, $urandom}, m, $urandom_range(0, 3), mode,
                $urandom_range(0, 6), {$urandom, $urandom},
                $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
                $urandom_range(0, 2));
        end

        // Reset while waiting for D aborts silently and clears the source ID
        old_src = src_model;
        issue_a(1, 32'h0002_0000, 64'h0, 8'h00, 0);
        tick();
        reset = 1'b0;
        req = 1'b0;
        tick();
        check("abort_no_ack", ack == 1'b0 && tl_a_valid == 1'b0, 128'({ack, tl_a_valid}), 128'(0));
        check("abort_d_ready", tl_d_ready == 1'b0, 128'(tl_d_ready), 128'(0));
        tick();
        reset = 1'b1;
        src_model = 2'd0;
        tick();
        drive_d(old_src, 3'd1, 64'hDEAD_0000_DEAD_0000, 1'b0, 1'b0);
        check("abort_idle_drain", tl_d_ready == 1'b1, 128'(tl_d_ready), 128'(1));
        tick();
        tl_d_valid = 1'b0;
        repeat (2) tick();
        txn(1, 32'h0002_0040, 64'h0, 8'h00, 0, 0, 1, 64'h0BAD_F00D_0000_0042, 0, 0, 0, 0);

        repeat (3) tick();
        check("queues_empty", a_q.size() == 0 && ack_q.size() == 0,
              128'({32'(a_q.size()), 32'(ack_q.size())}), 128'(0));
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
